// File: rtl/pipe_game_pkg.sv
// Shared types and widths for the pipe game scoring/collision block.
package pipe_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2
    } state_t;

    localparam int unsigned STATE_W      = 2;
    localparam int unsigned SCORE_DIGITS = 3;
    localparam int unsigned BCD_W        = 4;
    localparam int unsigned SCORE_W      = SCORE_DIGITS * BCD_W;

    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD up-counter with synchronous clear.
module bcd_counter
    import pipe_game_pkg::*;
#(
    parameter int unsigned DIGITS = SCORE_DIGITS
) (
    input  logic                      iClk,
    input  logic                      iRstN,
    input  logic                      iClr,
    input  logic                      iInc,
    output logic [DIGITS*BCD_W-1:0]   oBcd,
    output logic                      oSat
);

    localparam int unsigned W = DIGITS * BCD_W;

    logic [W-1:0] bcd_nxt;
    logic         sat_nxt;
    logic         carry;

    // Ripple the +1 through the digits; flag when the result is all nines
    always_comb begin
        bcd_nxt = oBcd;
        carry   = 1'b1;
        sat_nxt = 1'b1;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (carry) begin
                if (oBcd[d*BCD_W +: BCD_W] == BCD_MAX) begin
                    bcd_nxt[d*BCD_W +: BCD_W] = '0;
                end else begin
                    bcd_nxt[d*BCD_W +: BCD_W] = oBcd[d*BCD_W +: BCD_W] + BCD_W'(1);
                    carry = 1'b0;
                end
            end
            if (bcd_nxt[d*BCD_W +: BCD_W] != BCD_MAX) begin
                sat_nxt = 1'b0;
            end
        end
    end

    // Count register; once saturated further increments are dropped
    always_ff @(posedge iClk) begin
        if (!iRstN || iClr) begin
            oBcd <= '0;
            oSat <= 1'b0;
        end else if (iInc && !oSat) begin
            oBcd <= bcd_nxt;
            oSat <= sat_nxt;
        end
    end

endmodule

// File: rtl/pipe_score_collide.sv
// Game sequencer: collision detection, pass scoring, respawn and speed-up pulses.
module pipe_score_collide
    import pipe_game_pkg::*;
#(
    parameter int unsigned H_TOT          = 800,
    parameter int unsigned V_TOT          = 600,
    parameter int unsigned BIRD_X         = 100,
    parameter int unsigned BIRD_W         = 20,
    parameter int unsigned BIRD_H         = 20,
    parameter int unsigned PIPE_W         = 40,
    parameter int unsigned GAP_H          = 150,
    parameter int unsigned SPEED_STEP_PTS = 5,
    localparam int unsigned P_SIZE        = $clog2(H_TOT),
    localparam int unsigned V_SIZE        = $clog2(V_TOT)
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic               iGameStart,
    input  logic               iFrameTick,
    input  logic [P_SIZE-1:0]  iPipePos,
    input  logic               iPipeOut,
    input  logic [V_SIZE-1:0]  iGapTop,
    input  logic [V_SIZE-1:0]  iBirdY,
    output logic [STATE_W-1:0] oState,
    output logic               oCollision,
    output logic               oPipeRespawn,
    output logic               oPipeSpeedInc,
    output logic [SCORE_W-1:0] oScore
);

    localparam int unsigned PW     = P_SIZE + 1;
    localparam int unsigned VW     = V_SIZE + 1;
    localparam int unsigned STEP_W = (SPEED_STEP_PTS > 1) ? $clog2(SPEED_STEP_PTS) : 1;

    // One extra bit on every sum so edges near the screen limit never wrap
    logic [PW-1:0] pos_ext;
    logic [PW-1:0] pipe_right;
    logic [VW-1:0] y_ext;
    logic [VW-1:0] gap_ext;
    logic [VW-1:0] bird_bot;
    logic [VW-1:0] gap_bot;
    logic          xov;
    logic          safe;
    logic          ground;
    logic          hit;
    logic          pass;

    assign pos_ext    = PW'(iPipePos);
    assign pipe_right = pos_ext + PW'(PIPE_W - 1);
    assign y_ext      = VW'(iBirdY);
    assign gap_ext    = VW'(iGapTop);
    assign bird_bot   = y_ext + VW'(BIRD_H);
    assign gap_bot    = gap_ext + VW'(GAP_H);

    assign xov    = (pos_ext <= PW'(BIRD_X + BIRD_W - 1)) && (pipe_right >= PW'(BIRD_X));
    assign safe   = (y_ext >= gap_ext) && (bird_bot <= gap_bot);
    assign ground = (bird_bot > VW'(V_TOT));
    assign hit    = (xov && !safe) || ground;

    state_t              state, state_n;
    logic                collision, collision_n;
    logic                respawn, respawn_n;
    logic                speed_inc, speed_inc_n;
    logic                passed, passed_n;
    logic [STEP_W-1:0]   step, step_n;
    logic                score_clr;
    logic                score_inc;
    logic                score_sat;

    assign pass = !passed && (pipe_right < PW'(BIRD_X));

    // Score digits live in the shared saturating BCD counter
    bcd_counter #(
        .DIGITS (SCORE_DIGITS)
    ) u_score (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iClr  (score_clr),
        .iInc  (score_inc),
        .oBcd  (oScore),
        .oSat  (score_sat)
    );

    // Next-state and registered-output decode; pulses self-gate against back-to-back
    always_comb begin
        state_n     = state;
        collision_n = collision;
        respawn_n   = 1'b0;
        speed_inc_n = 1'b0;
        passed_n    = passed;
        step_n      = step;
        score_clr   = 1'b0;
        score_inc   = 1'b0;

        case (state)
            ST_IDLE, ST_HIT: begin
                if (iGameStart) begin
                    state_n     = ST_PLAY;
                    collision_n = 1'b0;
                    respawn_n   = !respawn;
                    passed_n    = 1'b0;
                    step_n      = '0;
                    score_clr   = 1'b1;
                end
            end
            ST_PLAY: begin
                if (iFrameTick) begin
                    if (hit) begin
                        state_n     = ST_HIT;
                        collision_n = 1'b1;
                    end else begin
                        if (pass) begin
                            passed_n = 1'b1;
                            if (!score_sat) begin
                                score_inc = 1'b1;
                                if (step == STEP_W'(SPEED_STEP_PTS - 1)) begin
                                    step_n      = '0;
                                    speed_inc_n = !speed_inc;
                                end else begin
                                    step_n = step + STEP_W'(1);
                                end
                            end
                        end
                        if (iPipeOut) begin
                            respawn_n = !respawn;
                            passed_n  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state     <= ST_IDLE;
            collision <= 1'b0;
            respawn   <= 1'b0;
            speed_inc <= 1'b0;
            passed    <= 1'b0;
            step      <= '0;
        end else begin
            state     <= state_n;
            collision <= collision_n;
            respawn   <= respawn_n;
            speed_inc <= speed_inc_n;
            passed    <= passed_n;
            step      <= step_n;
        end
    end

    assign oState        = state;
    assign oCollision    = collision;
    assign oPipeRespawn  = respawn;
    assign oPipeSpeedInc = speed_inc;

endmodule

// File: tb/tb_pipe_score_collide.sv
// Directed bench for pipe_score_collide with an integer-level reference model.
module tb_pipe_score_collide;

    localparam int V_TOT  = 600;
    localparam int BIRD_X = 100;
    localparam int BIRD_W = 20;
    localparam int BIRD_H = 20;
    localparam int PIPE_W = 40;
    localparam int GAP_H  = 150;
    localparam int STEP   = 5;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        tick;
    logic [9:0]  pipe_pos;
    logic        pipe_out;
    logic [9:0]  gap_top;
    logic [9:0]  bird_y;
    logic [1:0]  state;
    logic        collision;
    logic        respawn;
    logic        speed_inc;
    logic [11:0] score;

    int checks = 0;
    int errors = 0;

    pipe_score_collide dut (
        .iClk          (clk),
        .iRstN         (rst_n),
        .iGameStart    (start),
        .iFrameTick    (tick),
        .iPipePos      (pipe_pos),
        .iPipeOut      (pipe_out),
        .iGapTop       (gap_top),
        .iBirdY        (bird_y),
        .oState        (state),
        .oCollision    (collision),
        .oPipeRespawn  (respawn),
        .oPipeSpeedInc (speed_inc),
        .oScore        (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int s);
        logic [3:0] h, t, o;
        h = 4'(s / 100);
        t = 4'((s / 10) % 10);
        o = 4'(s % 10);
        return {h, t, o};
    endfunction

    // Reference model: score as a plain integer, geometry in int arithmetic
    int m_state, m_score, m_passed, m_step;
    bit m_coll, m_resp, m_spd, m_valid;
    int mp, my, mg;
    bit m_xov, m_safe, m_ground, r_n, s_n;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state = 0; m_score = 0; m_passed = 0; m_step = 0;
            m_coll = 0; m_resp = 0; m_spd = 0; m_valid = 1;
        end else begin
            r_n = 0;
            s_n = 0;
            if (m_state != 1 && start) begin
                m_state = 1; m_score = 0; m_passed = 0; m_step = 0; m_coll = 0;
                r_n = 1;
            end else if (m_state == 1 && tick) begin
                mp = int'(pipe_pos);
                my = int'(bird_y);
                mg = int'(gap_top);
                m_xov    = (mp <= BIRD_X + BIRD_W - 1) && (mp + PIPE_W - 1 >= BIRD_X);
                m_safe   = (my >= mg) && (my + BIRD_H <= mg + GAP_H);
                m_ground = (my + BIRD_H > V_TOT);
                if ((m_xov && !m_safe) || m_ground) begin
                    m_state = 2;
                    m_coll  = 1;
                end else begin
                    if (m_passed == 0 && mp + PIPE_W - 1 < BIRD_X) begin
                        m_passed = 1;
                        if (m_score < 999) begin
                            m_score++;
                            m_step++;
                            if (m_step == STEP) begin
                                m_step = 0;
                                s_n = !m_spd;
                            end
                        end
                    end
                    if (pipe_out) begin
                        r_n = !m_resp;
                        m_passed = 0;
                    end
                end
            end
            m_resp = r_n;
            m_spd  = s_n;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_valid) begin
            chk("state", int'(state), m_state);
            chk("collision", int'(collision), int'(m_coll));
            chk("respawn", int'(respawn), int'(m_resp));
            chk("speed_inc", int'(speed_inc), int'(m_spd));
            chk("score", int'(score), int'(to_bcd(m_score)));
        end
    end

    task automatic do_tick(input int pos, input bit out, input int gap, input int y);
        @(posedge clk) #1;
        pipe_pos = 10'(pos);
        pipe_out = out;
        gap_top  = 10'(gap);
        bird_y   = 10'(y);
        tick     = 1'b1;
        @(posedge clk) #1;
        tick     = 1'b0;
        pipe_out = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk) #1;
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
    endtask

    int pc;

    initial begin
        rst_n = 1'b0; start = 1'b0; tick = 1'b0; pipe_out = 1'b0;
        pipe_pos = 10'd700; gap_top = 10'd150; bird_y = 10'd200;

        // Reset and start
        @(posedge clk); @(posedge clk) #1;
        chk("rst_state", int'(state), 0);
        chk("rst_score", int'(score), 'h000);
        chk("rst_respawn", int'(respawn), 0);
        chk("rst_speed", int'(speed_inc), 0);
        chk("rst_coll", int'(collision), 0);
        rst_n = 1'b1;
        do_start();
        chk("start_state", int'(state), 1);
        chk("start_respawn", int'(respawn), 1);
        @(posedge clk) #1;
        chk("start_respawn_once", int'(respawn), 0);

        // Pass scoring
        do_tick(150, 0, 150, 200);
        chk("p150_state", int'(state), 1);
        do_tick(100, 0, 150, 200);
        chk("p100_state", int'(state), 1);
        chk("p100_score", int'(score), 'h000);
        do_tick(59, 0, 150, 200);
        chk("p59_score", int'(score), 'h001);
        do_tick(40, 0, 150, 200);
        do_tick(0, 0, 150, 200);
        chk("p0_score", int'(score), 'h001);
        do_tick(0, 1, 150, 200);
        chk("out_respawn", int'(respawn), 1);
        chk("out_score", int'(score), 'h001);

        // Collision with the pipe body
        do_tick(110, 0, 300, 200);
        chk("hit_state", int'(state), 2);
        chk("hit_coll", int'(collision), 1);
        chk("hit_score", int'(score), 'h001);
        do_tick(0, 1, 150, 200);
        chk("hit_hold", int'(state), 2);
        chk("hit_no_resp", int'(respawn), 0);
        do_start();
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score), 'h000);
        chk("restart_coll", int'(collision), 0);

        // Ground boundary
        do_tick(700, 0, 150, 580);
        chk("y580_state", int'(state), 1);
        do_tick(700, 0, 150, 581);
        chk("y581_state", int'(state), 2);
        do_start();

        // Speed pulses and BCD carry
        pc = 0;
        for (int i = 0; i < 10; i++) begin
            do_tick(0, 1, 150, 200);
            pc += int'(speed_inc);
            chk("spd_pulse", int'(speed_inc), (i == 4 || i == 9) ? 1 : 0);
        end
        chk("spd_count", pc, 2);
        chk("score10", int'(score), 'h010);

        // Start while playing is ignored
        do_start();
        chk("play_start_state", int'(state), 1);
        chk("play_start_score", int'(score), 'h010);
        chk("play_start_resp", int'(respawn), 0);

        // Saturation
        for (int i = 0; i < 989; i++) do_tick(0, 1, 150, 200);
        chk("score999", int'(score), 'h999);
        do_tick(0, 1, 150, 200);
        chk("sat_score", int'(score), 'h999);
        chk("sat_speed", int'(speed_inc), 0);
        chk("sat_respawn", int'(respawn), 1);

        // Reset during a tick
        @(posedge clk) #1;
        rst_n = 1'b0; tick = 1'b1; pipe_pos = 10'd0; pipe_out = 1'b1;
        @(posedge clk) #1;
        tick = 1'b0; pipe_out = 1'b0;
        chk("rst_tick_state", int'(state), 0);
        chk("rst_tick_score", int'(score), 'h000);
        chk("rst_tick_resp", int'(respawn), 0);
        chk("rst_tick_speed", int'(speed_inc), 0);
        rst_n = 1'b1;
        @(posedge clk); @(posedge clk) #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
